// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with an optional two-entry skid buffer,
// synchronous flush, control-bit masking and saturating stall/bubble counters.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 7,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [CTRL_W-1:0] i_in_ctrl,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [CTRL_W-1:0] o_out_ctrl,
   output logic [DATA_W-1:0] o_out_data,
   input  logic              i_flush,
   input  logic              i_cnt_clr,
   output logic [1:0]        o_occupancy,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              r_main_valid, r_skid_valid;
   logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
   logic [DATA_W-1:0] r_main_data, r_skid_data;
   logic [CNT_W-1:0]  r_stall_cnt, r_bubble_cnt;

   logic w_acc, w_pop, w_head_free, w_stall, w_bubble;

   // With the skid buffer, in_ready is registered state only, so the
   // downstream ready never reaches upstream combinationally.
   assign o_in_ready  = (SKID != 0) ? !r_skid_valid : (!r_main_valid | i_out_ready);
   assign w_acc       = i_in_valid & o_in_ready;
   assign w_pop       = r_main_valid & i_out_ready;
   assign w_head_free = !r_main_valid | i_out_ready;
   assign w_stall     = r_main_valid & !i_out_ready;
   assign w_bubble    = !r_main_valid & i_out_ready;

   assign o_out_valid = r_main_valid;
   assign o_out_ctrl  = r_main_valid ? r_main_ctrl : '0;
   assign o_out_data  = r_main_data;
   assign o_occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
   assign o_stall_cnt  = r_stall_cnt;
   assign o_bubble_cnt = r_bubble_cnt;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_main_valid <= 1'b0;
         r_main_ctrl  <= '0;
         r_main_data  <= '0;
         r_skid_valid <= 1'b0;
         r_skid_ctrl  <= '0;
         r_skid_data  <= '0;
      end else if (i_flush) begin
         // Payload registers keep their contents; only the valids drop.
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (SKID != 0) begin
         if (r_skid_valid) begin
            if (w_pop) begin
               r_main_valid <= 1'b1;
               r_main_ctrl  <= r_skid_ctrl;
               r_main_data  <= r_skid_data;
               r_skid_valid <= 1'b0;
            end
         end else if (w_acc) begin
            if (w_head_free) begin
               r_main_valid <= 1'b1;
               r_main_ctrl  <= i_in_ctrl;
               r_main_data  <= i_in_data;
            end else begin
               r_skid_valid <= 1'b1;
               r_skid_ctrl  <= i_in_ctrl;
               r_skid_data  <= i_in_data;
            end
         end else if (w_pop) begin
            r_main_valid <= 1'b0;
         end
      end else begin
         if (w_acc) begin
            r_main_valid <= 1'b1;
            r_main_ctrl  <= i_in_ctrl;
            r_main_data  <= i_in_data;
         end else if (w_pop) begin
            r_main_valid <= 1'b0;
         end
      end
   end

   // Counters see pre-edge out_valid/out_ready, flush cycles included.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else if (i_cnt_clr) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (w_stall && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         if (w_bubble && !(&r_bubble_cnt))
            r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data payload with a valid/ready handshake, an optional two-entry skid buffer that breaks the combinational ready path, and a synchronous flush that turns the stage into a bubble. On a bubble or flush, control bits are forced to zero. Saturating stall and bubble counters are included for pipeline performance monitoring.

## Interface
- DATA_W, 32, payload width (immediates, register data, register indices packed by the instantiator)
- CTRL_W, 7, control-bit width; these bits are forced to 0 whenever out_valid=0
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- CNT_W, 16, width of the performance counters
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream holds a valid entry
- in_ready  output  1  stage can accept an entry this cycle
- in_ctrl  input  CTRL_W  upstream control bits
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts the head this cycle
- out_ctrl  output  CTRL_W  head control bits; 0 when out_valid=0
- out_data  output  DATA_W  head payload; holds its last value when out_valid=0
- flush  input  1  synchronous kill of all held entries
- cnt_clr  input  1  synchronous clear of both counters
- occupancy  output  2  number of held entries (0..2; never exceeds 1 when SKID=0)
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  output  CNT_W  cycles with out_valid=0 and out_ready=1

## Operation
- Storage consists of a head register (main_valid, main_ctrl, main_data). When SKID=1 there is also a skid register (skid_valid, skid_ctrl, skid_data).
- Accept condition: acc = in_valid & in_ready. Pop condition: pop = out_valid & out_ready.
- SKID=0:
  - in_ready = !main_valid | out_ready (combinational).
  - On acc, the head loads the input. On pop without acc, main_valid clears.
- SKID=1:
  - in_ready = !skid_valid, which is a function of state only.
  - acc when the head is empty, or the head pops: the input goes to the head.
  - acc when the head is held (main_valid & !out_ready): the input goes to the skid register, and skid_valid sets.
  - pop with skid_valid: the skid entry moves to the head and skid_valid clears. No acc is possible in this cycle.
  - pop with neither skid_valid nor acc: main_valid clears.
- Order is FIFO. The skid entry never overtakes the head.
- flush has the highest priority. It clears main_valid and skid_valid. An acc in the same cycle is consumed from upstream and discarded. Data registers are not cleared.
- out_ctrl = main_valid ? main_ctrl : 0. out_valid = main_valid.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment; the counter value is 0 on the next cycle.
  - Counting is evaluated on the pre-edge values of out_valid and out_ready, including during flush cycles.

## Timing
- Reset (reset=0, asynchronous): out_valid=0, out_ctrl=0, out_data=0, skid contents 0, occupancy=0, stall_cnt=0, bubble_cnt=0.
  - in_ready=1 when SKID=1.
  - in_ready = 1 | out_ready = 1 when SKID=0.
- Reset deassertion takes effect at the next rising edge. No transfer occurs in the cycle reset is released asynchronously.
- Latency: an entry accepted at edge N appears with out_valid=1 at edge N+1 (1 cycle).
- Throughput: 1 entry/cycle sustained in both modes while out_ready=1.
- SKID=1: in_ready falls in the cycle after the first stalled accept. It rises in the cycle after the skid entry drains.
- Handshake rules:
  - out_valid, out_ctrl and out_data stay stable while out_valid=1 & out_ready=0, unless flush is asserted.
  - in_ready never depends combinationally on in_valid.
- Flush takes effect at the edge where it is sampled: out_valid=0 and occupancy=0 on the next cycle, regardless of out_ready.
- Reset mid-operation discards all entries immediately and clears the counters.

## Test plan
- Reset then stream: reset low for 3 cycles, then in_valid=1 with in_data=0x11, 0x22, 0x33 on consecutive cycles and out_ready=1 -> out_data 0x11/0x22/0x33 on cycles 1/2/3 after the first accept; bubble_cnt=1 (the cycle before the first output); in_ready stays 1.
- Skid fill (SKID=1): head=0xA1 with out_ready=0, push 0xB2 -> occupancy=2, in_ready=0 next cycle, stall_cnt increments each cycle. Raise out_ready -> outputs 0xA1 then 0xB2, then in_ready=1.
- Flush with a full skid buffer while in_valid=1 carries 0xC3 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xC3 is never output.
- Control masking: in_ctrl=7'h7F accepted then drained with no new input -> out_ctrl=7'h7F for one cycle, then 0; out_data holds its last value.
- Counter saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15. Pulse cnt_clr -> 0 on the next cycle, then counting resumes.
- SKID=0 mode: out_ready=0 with the head full -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 combinationally, and a simultaneous accept replaces the head with no bubble.
